trig_gen: RTL and testbench

- Parametrised trigger generator for the AD sampling path.
- Converts the AD sample stream into a level signal using a hysteresis comparator with runtime-set hysteresis.
- Removes glitches with a consecutive-sample filter and emits a one-cycle trigger strobe on the selected edge.
- Supports holdoff, continuous or single-shot arming, and a trigger counter. Sits between the AD capture interface and the frequency-measurement / capture-control logic.

---
 rtl/trig_gen.sv | 100 ++++++++++
 tb/tb_trig_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/trig_gen.sv
// trig_gen: hysteresis comparator, glitch filter and edge-trigger FSM for the AD sampling path
module trig_gen #(
   parameter int DATA_W = 8,
   parameter int FILT_W = 4,
   parameter int HOLD_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              ad_clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] ad_data,
   input  logic [DATA_W-1:0] trig_level,
   input  logic [DATA_W-1:0] hyst,
   input  logic              edge_sel,
   input  logic [FILT_W-1:0] filt_len,
   input  logic [HOLD_W-1:0] holdoff,
   input  logic              mode_single,
   input  logic              arm,
   input  logic              clr_cnt,
   output logic              ad_pulse,
   output logic              trig,
   output logic              armed,
   output logic [CNT_W-1:0]  trig_cnt
);
   typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;
   state_t state_q, state_d;
   logic raw_q, raw_d, pulse_q, pulse_d, p_q, trig_q, trig_d, armed_q, fire, edge_det;
   logic [FILT_W-1:0] fcnt_q, fcnt_d, flen;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W:0] hi, lo;
   assign hi = {1'b0, trig_level} + {1'b0, hyst};
   assign lo = {1'b0, trig_level} - {1'b0, hyst};
   assign flen = (filt_len == '0) ? FILT_W'(1) : filt_len;
   assign edge_det = edge_sel ? (~pulse_q & p_q) : (pulse_q & ~p_q);
   assign fire = (state_q == ARMED) && edge_det;
   // comparator: thresholds are one bit wider so they never wrap; out-of-range thresholds just hold
   always_comb begin
      raw_d = ({1'b0, ad_data} > hi) ? 1'b1 :
              ((trig_level >= hyst) && ({1'b0, ad_data} < lo)) ? 1'b0 : raw_q;
   end
   // glitch filter: raw must disagree with ad_pulse for flen consecutive cycles to be accepted
   always_comb begin
      pulse_d = pulse_q;
      fcnt_d = '0;
      if (raw_q != pulse_q) begin
         if (fcnt_q + FILT_W'(1) == flen) pulse_d = raw_q;
         else fcnt_d = fcnt_q + FILT_W'(1);
      end
   end
   // trigger FSM next state, holdoff countdown and trigger counter
   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      trig_d = 1'b0;
      cnt_d = clr_cnt ? CNT_W'(fire) : cnt_q + CNT_W'(fire);
      case (state_q)
         IDLE: if (!mode_single || arm) state_d = ARMED;
         ARMED: if (fire) begin
            trig_d = 1'b1;
            if (holdoff != '0) begin
               hold_d = holdoff;
               state_d = HOLD;
            end else if (mode_single) state_d = IDLE;
         end
         HOLD: begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) state_d = mode_single ? IDLE : ARMED;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers; reset discards any filter or holdoff progress
   always_ff @(posedge ad_clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         raw_q <= 1'b0;
         pulse_q <= 1'b0;
         p_q <= 1'b0;
         fcnt_q <= '0;
         hold_q <= '0;
         cnt_q <= '0;
         trig_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         raw_q <= raw_d;
         pulse_q <= pulse_d;
         p_q <= pulse_q;
         fcnt_q <= fcnt_d;
         hold_q <= hold_d;
         cnt_q <= cnt_d;
         trig_q <= trig_d;
         armed_q <= (state_d == ARMED);
      end
   end
   assign ad_pulse = pulse_q;
   assign trig = trig_q;
   assign armed = armed_q;
   assign trig_cnt = cnt_q;
endmodule

// File: tb/tb_trig_gen.sv
// tb_trig_gen: scenario tasks with a per-cycle scoreboard of expected outputs
module tb_trig_gen;
   logic ad_clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] ad_data = 8'd0;
   logic [7:0] trig_level = 8'd128;
   logic [7:0] hyst = 8'd3;
   logic edge_sel = 1'b0;
   logic [3:0] filt_len = 4'd1;
   logic [15:0] holdoff = 16'd0;
   logic mode_single = 1'b0;
   logic arm = 1'b0;
   logic clr_cnt = 1'b0;
   logic ad_pulse, trig, armed, pulse_s, trig_s, armed_s;
   logic [15:0] trig_cnt;
   logic [1:0] cnt_small;
   int n_pass = 0;
   int n_tot = 0;
   typedef struct {
      logic pulse;
      logic trig;
      logic armed;
      bit cp;
      bit ca;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   trig_gen u_dut (
      .ad_clk(ad_clk), .rst_n(rst_n), .ad_data(ad_data), .trig_level(trig_level), .hyst(hyst),
      .edge_sel(edge_sel), .filt_len(filt_len), .holdoff(holdoff), .mode_single(mode_single),
      .arm(arm), .clr_cnt(clr_cnt), .ad_pulse(ad_pulse), .trig(trig), .armed(armed), .trig_cnt(trig_cnt)
   );
   trig_gen #(.CNT_W(2)) u_small (
      .ad_clk(ad_clk), .rst_n(rst_n), .ad_data(ad_data), .trig_level(trig_level), .hyst(hyst),
      .edge_sel(edge_sel), .filt_len(filt_len), .holdoff(holdoff), .mode_single(mode_single),
      .arm(arm), .clr_cnt(clr_cnt), .ad_pulse(pulse_s), .trig(trig_s), .armed(armed_s), .trig_cnt(cnt_small)
   );

   always #5 ad_clk = ~ad_clk;

   task automatic tick();
      @(posedge ad_clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ad_data = (i % 2 == 0) ? 8'd255 : 8'd0;
         tick();
      end
      n_tot++; if (ad_pulse !== 1'b0) $display("FAIL reset_pulse got %b exp 0", ad_pulse); else n_pass++;
      n_tot++; if (trig !== 1'b0) $display("FAIL reset_trig got %b exp 0", trig); else n_pass++;
      n_tot++; if (armed !== 1'b0) $display("FAIL reset_armed got %b exp 0", armed); else n_pass++;
      n_tot++; if (trig_cnt !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", trig_cnt); else n_pass++;
      rst_n = 1'b1;
      ad_data = 8'd0;
      tick();
      n_tot++; if (armed !== 1'b1) $display("FAIL release_armed got %b exp 1", armed); else n_pass++;
   endtask

   task automatic test_hysteresis();
      for (int k = 0; k <= 40; k++) begin
         ad_data = (k <= 20) ? 8'(120 + k) : 8'(160 - k);
         sb.push_back('{(k >= 13 && k <= 36), (k == 14), 1'b1, 1'b1, 1'b1});
         tick();
         e = sb.pop_front();
         n_tot++; if (ad_pulse !== e.pulse) $display("FAIL hyst_pulse k=%0d got %b exp %b", k, ad_pulse, e.pulse); else n_pass++;
         n_tot++; if (trig !== e.trig) $display("FAIL hyst_trig k=%0d got %b exp %b", k, trig, e.trig); else n_pass++;
         n_tot++; if (armed !== e.armed) $display("FAIL hyst_armed k=%0d got %b exp %b", k, armed, e.armed); else n_pass++;
      end
      n_tot++; if (trig_cnt !== 16'd1) $display("FAIL hyst_cnt got %0d exp 1", trig_cnt); else n_pass++;
   endtask

   task automatic test_boundary();
      trig_level = 8'd2;
      for (int k = 0; k < 14; k++) begin
         ad_data = (k < 4) ? 8'd255 : 8'd0;
         sb.push_back('{1'b1, 1'b0, 1'b1, (k >= 4), 1'b0});
         tick();
         e = sb.pop_front();
         if (e.cp) begin
            n_tot++; if (ad_pulse !== e.pulse) $display("FAIL low_bound_pulse k=%0d got %b exp %b", k, ad_pulse, e.pulse); else n_pass++;
         end
      end
      trig_level = 8'd254;
      for (int k = 0; k < 14; k++) begin
         ad_data = (k < 4) ? 8'd0 : 8'd255;
         sb.push_back('{1'b0, 1'b0, 1'b1, (k >= 4), 1'b0});
         tick();
         e = sb.pop_front();
         if (e.cp) begin
            n_tot++; if (ad_pulse !== e.pulse) $display("FAIL high_bound_pulse k=%0d got %b exp %b", k, ad_pulse, e.pulse); else n_pass++;
            n_tot++; if (trig !== e.trig) $display("FAIL high_bound_trig k=%0d got %b exp %b", k, trig, e.trig); else n_pass++;
         end
      end
   endtask

   task automatic test_glitch();
      trig_level = 8'd128;
      filt_len = 4'd4;
      for (int k = 0; k < 14; k++) begin
         ad_data = (k >= 3 && k < 6) ? 8'd200 : 8'd100;
         sb.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
         tick();
         e = sb.pop_front();
         n_tot++; if (ad_pulse !== e.pulse) $display("FAIL glitch3_pulse k=%0d got %b exp %b", k, ad_pulse, e.pulse); else n_pass++;
         n_tot++; if (trig !== e.trig) $display("FAIL glitch3_trig k=%0d got %b exp %b", k, trig, e.trig); else n_pass++;
      end
      for (int j = 0; j < 16; j++) begin
         ad_data = (j < 4) ? 8'd200 : 8'd100;
         sb.push_back('{(j >= 4 && j <= 7), (j == 5), 1'b1, 1'b1, 1'b0});
         tick();
         e = sb.pop_front();
         n_tot++; if (ad_pulse !== e.pulse) $display("FAIL glitch4_pulse j=%0d got %b exp %b", j, ad_pulse, e.pulse); else n_pass++;
         n_tot++; if (trig !== e.trig) $display("FAIL glitch4_trig j=%0d got %b exp %b", j, trig, e.trig); else n_pass++;
      end
   endtask

   task automatic test_holdoff_falling();
      filt_len = 4'd1;
      edge_sel = 1'b1;
      holdoff = 16'd10;
      for (int k = 0; k < 32; k++) begin
         ad_data = (k % 6 < 3) ? 8'd200 : 8'd100;
         sb.push_back('{1'b0, (k == 5 || k == 17 || k == 29),
                        (k < 5 || k == 15 || k == 16 || k == 27 || k == 28), 1'b0, 1'b1});
         tick();
         e = sb.pop_front();
         n_tot++; if (trig !== e.trig) $display("FAIL hold_trig k=%0d got %b exp %b", k, trig, e.trig); else n_pass++;
         n_tot++; if (armed !== e.armed) $display("FAIL hold_armed k=%0d got %b exp %b", k, armed, e.armed); else n_pass++;
      end
   endtask

   task automatic test_single_shot();
      mode_single = 1'b1;
      holdoff = 16'd0;
      edge_sel = 1'b0;
      ad_data = 8'd100;
      repeat (15) tick();
      for (int k = 0; k < 12; k++) begin
         ad_data = (k % 6 < 3) ? 8'd200 : 8'd100;
         sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
         tick();
         e = sb.pop_front();
         n_tot++; if (trig !== e.trig) $display("FAIL noarm_trig k=%0d got %b exp %b", k, trig, e.trig); else n_pass++;
         n_tot++; if (armed !== e.armed) $display("FAIL noarm_armed k=%0d got %b exp %b", k, armed, e.armed); else n_pass++;
      end
      for (int k = 0; k < 12; k++) begin
         ad_data = ((k >= 2 && k <= 5) || k >= 9) ? 8'd200 : 8'd100;
         arm = (k == 0);
         clr_cnt = (k == 4);
         sb.push_back('{1'b0, (k == 4), (k <= 3), 1'b0, 1'b1});
         tick();
         e = sb.pop_front();
         n_tot++; if (trig !== e.trig) $display("FAIL single_trig k=%0d got %b exp %b", k, trig, e.trig); else n_pass++;
         n_tot++; if (armed !== e.armed) $display("FAIL single_armed k=%0d got %b exp %b", k, armed, e.armed); else n_pass++;
         if (k == 4) begin
            n_tot++; if (trig_cnt !== 16'd1) $display("FAIL clr_with_trig_cnt got %0d exp 1", trig_cnt); else n_pass++;
         end
      end
      arm = 1'b0;
      clr_cnt = 1'b0;
      n_tot++; if (trig_cnt !== 16'd1) $display("FAIL single_cnt_end got %0d exp 1", trig_cnt); else n_pass++;
   endtask

   task automatic test_counter_wrap();
      mode_single = 1'b0;
      ad_data = 8'd100;
      clr_cnt = 1'b1;
      repeat (4) tick();
      clr_cnt = 1'b0;
      n_tot++; if (trig_cnt !== 16'd0) $display("FAIL clr_only_cnt got %0d exp 0", trig_cnt); else n_pass++;
      for (int k = 0; k < 34; k++) begin
         ad_data = (k < 30 && k % 6 < 3) ? 8'd200 : 8'd100;
         sb.push_back('{1'b0, (k < 30 && k % 6 == 2), 1'b1, 1'b0, 1'b0});
         tick();
         e = sb.pop_front();
         n_tot++; if (trig !== e.trig) $display("FAIL wrap_trig k=%0d got %b exp %b", k, trig, e.trig); else n_pass++;
      end
      n_tot++; if (trig_cnt !== 16'd5) $display("FAIL wide_cnt got %0d exp 5", trig_cnt); else n_pass++;
      n_tot++; if (cnt_small !== 2'd1) $display("FAIL wrap_cnt got %0d exp 1", cnt_small); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_hysteresis();
      test_boundary();
      test_glitch();
      test_holdoff_falling();
      test_single_shot();
      test_counter_wrap();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
